// File: rtl/vga_timing_generator_pkg.sv
// Shared types and default raster timing for the VGA timing generator.
// Optional feature macro honoured by the top: VGA_TEST_PATTERN_EN.
`include "global_symbols.vh"

package vga_timing_generator_pkg;

    localparam int unsigned CNT_W = 12;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned DEF_H_ACTIVE = `H_ACTIVE;
    localparam int unsigned DEF_H_FRONT  = `H_FRONT;
    localparam int unsigned DEF_H_SYNC   = `H_SYNC;
    localparam int unsigned DEF_H_BACK   = `H_BACK;
    localparam int unsigned DEF_V_ACTIVE = `V_ACTIVE;
    localparam int unsigned DEF_V_FRONT  = `V_FRONT;
    localparam int unsigned DEF_V_SYNC   = `V_SYNC;
    localparam int unsigned DEF_V_BACK   = `V_BACK;

endpackage

// File: rtl/global_symbols.vh
// Global raster timing symbols for the 640x480@60 display path.
`ifndef GLOBAL_SYMBOLS_VH
`define GLOBAL_SYMBOLS_VH

`define H_ACTIVE     640
`define H_FRONT      16
`define H_SYNC       96
`define H_BACK       48
`define H_TOTAL      (`H_ACTIVE + `H_FRONT + `H_SYNC + `H_BACK)

`define V_ACTIVE     480
`define V_FRONT      10
`define V_SYNC       2
`define V_BACK       33
`define V_TOTAL      (`V_ACTIVE + `V_FRONT + `V_SYNC + `V_BACK)

`define FRAME_WIDTH  `H_ACTIVE
`define FRAME_HEIGHT `V_ACTIVE

`endif

// File: rtl/vga_timing_generator_axis.sv
// One raster axis: free-running counter with wrap strobe and active-low sync.
module vga_axis_counter
    import vga_timing_generator_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_LEN   = 96
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output cnt_t count,
    output logic wrap,
    output logic sync_n
);

    localparam cnt_t LAST     = cnt_t'(TOTAL - 1);
    localparam cnt_t SYNC_BEG = cnt_t'(SYNC_START);
    localparam cnt_t SYNC_END = cnt_t'(SYNC_START + SYNC_LEN);

    assign wrap   = enable && (count == LAST);
    assign sync_n = !((count >= SYNC_BEG) && (count < SYNC_END));

    // Advance when enabled, returning to zero after the last position
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing: 1-based x/y for the image generator, frame tick,
// and blanked colour plus sync pins aligned one cycle after x/y.
// Optional macro VGA_TEST_PATTERN_EN replaces the colour input with bars.
module vga_timing_generator
    import vga_timing_generator_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    output logic        frame_tick,
    output logic [2:0]  vga_color,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);

    cnt_t       h_cnt;
    cnt_t       v_cnt;
    logic       h_wrap;
    logic       v_wrap_unused;
    logic       h_sync_n;
    logic       v_sync_n;
    logic       visible;
    logic       hs_s0;
    logic       vs_s0;
    logic [2:0] pix_color;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FRONT),
        .SYNC_LEN   (H_SYNC)
    ) u_h_axis (
        .clk    (CLOCK_25),
        .reset  (reset),
        .enable (1'b1),
        .count  (h_cnt),
        .wrap   (h_wrap),
        .sync_n (h_sync_n)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FRONT),
        .SYNC_LEN   (V_SYNC)
    ) u_v_axis (
        .clk    (CLOCK_25),
        .reset  (reset),
        .enable (h_wrap),
        .count  (v_cnt),
        .wrap   (v_wrap_unused),
        .sync_n (v_sync_n)
    );

    assign visible = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);

    // Stage 0: coordinates, visibility, frame tick and raw sync from the counters
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            active     <= 1'b0;
            frame_tick <= 1'b0;
            hs_s0      <= 1'b1;
            vs_s0      <= 1'b1;
        end else begin
            x          <= visible ? h_cnt + 1'b1 : '0;
            y          <= visible ? v_cnt + 1'b1 : '0;
            active     <= visible;
            frame_tick <= (h_cnt == '0) && (v_cnt == V_ACT_C);
            hs_s0      <= h_sync_n;
            vs_s0      <= v_sync_n;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam cnt_t BAR_W = cnt_t'(H_ACTIVE / 8);

    logic unused_color;
    assign unused_color = ^color;

    // Eight vertical bars framed by a one-pixel white border
    always_comb begin
        pix_color = 3'((x - cnt_t'(1)) / BAR_W);
        if ((x == cnt_t'(1)) || (x == H_ACT_C) || (y == cnt_t'(1)) || (y == V_ACT_C)) begin
            pix_color = 3'b111;
        end
    end
`else
    // Colour comes straight from the image generator for the current x/y
    always_comb begin
        pix_color = color;
    end
`endif

    // Stage 1: blanked colour and sync delayed together so the pins stay aligned
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            vga_color <= '0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
        end else begin
            vga_color <= active ? pix_color : '0;
            vga_hs    <= hs_s0;
            vga_vs    <= vs_s0;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench: default 640x480 instance plus a shrunken-timing instance
// so whole frames fit in a short run.
module tb_vga_timing_generator;

    logic        CLOCK_25 = 1'b0;
    logic        rst [2];
    logic [2:0]  color;
    logic [11:0] dx [2];
    logic [11:0] dy [2];
    logic        dact [2];
    logic        dft [2];
    logic [2:0]  dcol [2];
    logic        dhs [2];
    logic        dvs [2];

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;

    always #20 CLOCK_25 = ~CLOCK_25;

    vga_timing_generator dut (
        .CLOCK_25(CLOCK_25), .reset(rst[0]), .color(color),
        .x(dx[0]), .y(dy[0]), .active(dact[0]), .frame_tick(dft[0]),
        .vga_color(dcol[0]), .vga_hs(dhs[0]), .vga_vs(dvs[0])
    );

    vga_timing_generator #(
        .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
    ) dut_s (
        .CLOCK_25(CLOCK_25), .reset(rst[1]), .color(color),
        .x(dx[1]), .y(dy[1]), .active(dact[1]), .frame_tick(dft[1]),
        .vga_color(dcol[1]), .vga_hs(dhs[1]), .vga_vs(dvs[1])
    );

    // Timing of each instance, taken from the raster definition
    int unsigned HA [2] = '{640, 16};
    int unsigned HF [2] = '{16, 4};
    int unsigned HS [2] = '{96, 6};
    int unsigned HB [2] = '{48, 6};
    int unsigned VA [2] = '{480, 12};
    int unsigned VF [2] = '{10, 2};
    int unsigned VS [2] = '{2, 2};
    int unsigned VB [2] = '{33, 4};

    // Reference model state
    int unsigned mh [2];
    int unsigned mv [2];
    logic [11:0] ex [2];
    logic [11:0] ey [2];
    logic        eact [2];
    logic        eft [2];
    logic        ehs0 [2];
    logic        evs0 [2];
    logic        ehs [2];
    logic        evs [2];

    logic [2:0] q0 [$];
    logic [2:0] q1 [$];

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] first_px = 3'b111;
`else
    logic [2:0] first_px = 3'b101;
`endif

    // Reference raster model, one step per clock edge
    always @(posedge CLOCK_25) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                mh[i] = 0; mv[i] = 0; ex[i] = 0; ey[i] = 0;
                eact[i] = 0; eft[i] = 0;
                ehs0[i] = 1; evs0[i] = 1; ehs[i] = 1; evs[i] = 1;
            end else begin
                ehs[i]  = ehs0[i];
                evs[i]  = evs0[i];
                eact[i] = (mh[i] < HA[i]) && (mv[i] < VA[i]);
                ex[i]   = eact[i] ? 12'(mh[i] + 1) : 12'd0;
                ey[i]   = eact[i] ? 12'(mv[i] + 1) : 12'd0;
                eft[i]  = (mh[i] == 0) && (mv[i] == VA[i]);
                ehs0[i] = !((mh[i] >= HA[i] + HF[i]) && (mh[i] < HA[i] + HF[i] + HS[i]));
                evs0[i] = !((mv[i] >= VA[i] + VF[i]) && (mv[i] < VA[i] + VF[i] + VS[i]));
                if (mh[i] == HA[i] + HF[i] + HS[i] + HB[i] - 1) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] == VA[i] + VF[i] + VS[i] + VB[i] - 1) ? 0 : mv[i] + 1;
                end else begin
                    mh[i] = mh[i] + 1;
                end
            end
        end
    end

    function automatic logic [2:0] exp_pin(input int i, input logic [2:0] c);
        int unsigned b;
        if (!eact[i]) return 3'd0;
`ifdef VGA_TEST_PATTERN_EN
        if (ex[i] == 12'd1 || ex[i] == 12'(HA[i]) || ey[i] == 12'd1 || ey[i] == 12'(VA[i]))
            return 3'b111;
        b = (int'(ex[i]) - 1) / (HA[i] / 8);
        return b[2:0];
`else
        b = 0;
        return c | b[2:0];
`endif
    endfunction

    // Drive one cycle of stimulus, record the expected pin colour, advance
    task automatic cycle(input logic [2:0] c, input logic r0, input logic r1);
        color  = c;
        rst[0] = r0;
        rst[1] = r1;
        q0.push_back(r0 ? 3'd0 : exp_pin(0, c));
        q1.push_back(r1 ? 3'd0 : exp_pin(1, c));
        @(negedge CLOCK_25);
        #1;
    endtask

    // Scoreboard: every cycle compare both instances against the model
    always @(negedge CLOCK_25) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [2:0] e;
                tests += 6;
                if (dx[i] !== ex[i]) begin fails++; $display("FAIL x[%0d] got %0d expected %0d", i, dx[i], ex[i]); end
                if (dy[i] !== ey[i]) begin fails++; $display("FAIL y[%0d] got %0d expected %0d", i, dy[i], ey[i]); end
                if (dact[i] !== eact[i]) begin fails++; $display("FAIL active[%0d] got %b expected %b", i, dact[i], eact[i]); end
                if (dft[i] !== eft[i]) begin fails++; $display("FAIL frame_tick[%0d] got %b expected %b", i, dft[i], eft[i]); end
                if (dhs[i] !== ehs[i]) begin fails++; $display("FAIL vga_hs[%0d] got %b expected %b", i, dhs[i], ehs[i]); end
                if (dvs[i] !== evs[i]) begin fails++; $display("FAIL vga_vs[%0d] got %b expected %b", i, dvs[i], evs[i]); end
                if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    tests++;
                    if (dcol[i] !== e) begin fails++; $display("FAIL vga_color[%0d] got %0b expected %0b", i, dcol[i], e); end
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) cycle(3'b101, 1, 1);
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (dx[i] !== 0 || dy[i] !== 0 || dact[i] !== 0 || dft[i] !== 0 ||
                dcol[i] !== 0 || dhs[i] !== 1 || dvs[i] !== 1) begin
                fails++;
                $display("FAIL reset_state[%0d] got x=%0d y=%0d act=%b ft=%b col=%0b hs=%b vs=%b expected 0 0 0 0 0 1 1",
                         i, dx[i], dy[i], dact[i], dft[i], dcol[i], dhs[i], dvs[i]);
            end
        end
        q0.delete();
        q1.delete();
        mon_en = 1;
        cycle(3'b101, 0, 0);
        tests++;
        if (dx[0] !== 1 || dy[0] !== 1 || dact[0] !== 1 || dhs[0] !== 1 || dvs[0] !== 1 || dcol[0] !== 0) begin
            fails++;
            $display("FAIL first_pixel got x=%0d y=%0d act=%b hs=%b vs=%b col=%0b expected 1 1 1 1 1 0",
                     dx[0], dy[0], dact[0], dhs[0], dvs[0], dcol[0]);
        end
        cycle(3'b101, 0, 0);
        tests++;
        if (dcol[0] !== first_px || dx[0] !== 2) begin
            fails++;
            $display("FAIL first_colour got col=%0b x=%0d expected %0b 2", dcol[0], dx[0], first_px);
        end
    endtask

    task automatic test_line();
        int t1 = -1, t2 = -1, thf = -1, tlow = 0, nact = 0;
        logic phs = 1'b1;
        for (int n = 0; n < 2000 && t2 < 0; n++) begin
            cycle(3'($urandom), 0, 0);
            if (dx[0] == 12'd1) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
            if (t1 >= 0 && t2 < 0) begin
                if (dact[0]) nact++;
                if (!dhs[0]) tlow++;
                if (phs && !dhs[0] && thf < 0) thf = n;
            end
            phs = dhs[0];
        end
        tests += 4;
        if (t2 - t1 != 800) begin fails++; $display("FAIL line_period got %0d expected 800", t2 - t1); end
        if (thf - t1 != 657) begin fails++; $display("FAIL hs_fall got %0d expected 657", thf - t1); end
        if (tlow != 96) begin fails++; $display("FAIL hs_width got %0d expected 96", tlow); end
        if (nact != 640) begin fails++; $display("FAIL active_per_line got %0d expected 640", nact); end
    endtask

    task automatic test_blanking();
        int lit = 0, after640 = 0;
        for (int n = 0; n < 900; n++) begin
            cycle(3'b101, 0, 0);
            if (n < 800 && dcol[0] == 3'b101) lit++;
            if (after640 == 1) begin
                tests++;
                if (dcol[0] !== first_px && dcol[0] !== 3'b111) begin
                    fails++; $display("FAIL colour_at_640 got %0b expected %0b", dcol[0], first_px);
                end
                after640 = 2;
            end else if (after640 == 2) begin
                tests++;
                if (dcol[0] !== 3'b000) begin fails++; $display("FAIL colour_after_640 got %0b expected 000", dcol[0]); end
                after640 = 3;
            end
            if (dx[0] == 12'd640 && after640 == 0) after640 = 1;
        end
        tests++;
        if (after640 != 3) begin fails++; $display("FAIL x640_seen got %0d expected 3", after640); end
`ifndef VGA_TEST_PATTERN_EN
        tests++;
        if (lit != 640) begin fails++; $display("FAIL lit_per_line got %0d expected 640", lit); end
`endif
    endtask

    task automatic test_frame();
        int found = 0, period = -1, vlow = 0, vfall = -1, nact = 0, lit = 0, lasty = 0;
        for (int n = 0; n < 700 && found == 0; n++) begin
            cycle(3'b101, 0, 0);
            if (dft[1]) found = 1;
        end
        for (int n = 1; n < 700 && period < 0 && found == 1; n++) begin
            cycle(3'b101, 0, 0);
            if (dft[1]) begin
                period = n;
            end else begin
                if (!dvs[1]) begin vlow++; if (vfall < 0) vfall = n; end
                if (dact[1]) nact++;
                if (dcol[1] == 3'b101) lit++;
                if (dy[1] != 0) lasty = int'(dy[1]);
            end
        end
        tests += 5;
        if (period != 640) begin fails++; $display("FAIL frame_period got %0d expected 640", period); end
        if (vlow != 64) begin fails++; $display("FAIL vs_width got %0d expected 64", vlow); end
        if (vfall != 65) begin fails++; $display("FAIL vs_fall got %0d expected 65", vfall); end
        if (nact != 192) begin fails++; $display("FAIL active_per_frame got %0d expected 192", nact); end
        if (lasty != 12) begin fails++; $display("FAIL last_row got %0d expected 12", lasty); end
`ifndef VGA_TEST_PATTERN_EN
        tests++;
        if (lit != 192) begin fails++; $display("FAIL lit_per_frame got %0d expected 192", lit); end
`endif
    endtask

    task automatic test_reset_midline();
        int t1 = -1, thf = -1;
        logic phs;
        for (int n = 0; n < 1000 && mh[0] != 700; n++) cycle(3'($urandom), 0, 0);
        tests++;
        if (dhs[0] !== 1'b0) begin fails++; $display("FAIL hs_before_reset got %b expected 0", dhs[0]); end
        cycle(3'b011, 1, 0);
        tests++;
        if (dhs[0] !== 1 || dx[0] !== 0 || dy[0] !== 0 || dact[0] !== 0 || dcol[0] !== 0) begin
            fails++;
            $display("FAIL midline_reset got hs=%b x=%0d y=%0d act=%b col=%0b expected 1 0 0 0 0",
                     dhs[0], dx[0], dy[0], dact[0], dcol[0]);
        end
        cycle(3'b011, 0, 0);
        tests++;
        if (dx[0] !== 1 || dy[0] !== 1 || dact[0] !== 1) begin
            fails++; $display("FAIL restart got x=%0d y=%0d act=%b expected 1 1 1", dx[0], dy[0], dact[0]);
        end
        t1 = 0;
        phs = dhs[0];
        for (int n = 1; n < 1000 && thf < 0; n++) begin
            cycle(3'($urandom), 0, 0);
            if (phs && !dhs[0]) thf = n;
            phs = dhs[0];
        end
        tests++;
        if (thf - t1 != 657) begin fails++; $display("FAIL hs_fall_after_reset got %0d expected 657", thf - t1); end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [2:0] want;
        int found = 0;
        for (int n = 0; n < 2000 && found == 0; n++) begin
            cycle(3'b010, 0, 0);
            if (dy[0] == 12'd2 && dx[0] == 12'd1) found = 1;
        end
        tests++;
        if (found == 0) begin fails++; $display("FAIL pattern_row got 0 expected 1"); end
        for (int k = 1; k <= 81; k++) begin
            cycle(3'b010, 0, 0);
            want = (k == 1) ? 3'b111 : (k <= 80) ? 3'b000 : 3'b001;
            tests++;
            if (dcol[0] !== want) begin fails++; $display("FAIL pattern_x%0d got %0b expected %0b", k, dcol[0], want); end
        end
        for (int n = 0; n < 700 && dx[0] != 12'd640; n++) cycle(3'b010, 0, 0);
        cycle(3'b010, 0, 0);
        tests++;
        if (dcol[0] !== 3'b111) begin fails++; $display("FAIL pattern_x640 got %0b expected 111", dcol[0]); end
    endtask
`endif

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        color  = 3'b000;
        test_reset();
        test_line();
        test_blanking();
        test_frame();
        test_reset_midline();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        cycle(3'b000, 0, 0);
        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
